bullet_ctrl: RTL

BULLET_CTRL -- requirements
Module: bullet_ctrl

---
 rtl/bullet_ctrl_pkg.sv | 17 +
 rtl/bullet_tick.sv | 30 +++
 rtl/bullet_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bullet_ctrl_pkg.sv
// Shared game definitions: playfield grid and bullet FSM state encoding.
package bullet_ctrl_pkg;

    localparam int GRID_COLS  = 20;
    localparam int GRID_ROWS  = 16;
    localparam int PLAYER_ROW = 15;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } bullet_state_t;

endpackage

// File: rtl/bullet_tick.sv
// Step prescaler: free-running 0..SPEED-1 counter with a one-cycle tick at
// the terminal count and a synchronous restart to zero.
module bullet_tick #(
    parameter int SPEED = 25000
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (SPEED > 1) ? $clog2(SPEED) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPEED - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Count up, wrapping after the terminal count or when restarted.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet controller: launches on a fire-button press, climbs one row
// per step tick, and either leaves the top of the screen (miss) or is
// consumed by a hit and waits out a short cooldown.
module bullet_ctrl
    import bullet_ctrl_pkg::*;
#(
    parameter int SPEED     = 25000,
    parameter int COOLDOWN  = 4,
    parameter int START_ROW = 14
) (
    input  logic             i_clk_25MHz,
    input  logic             i_reset,
    input  logic             i_fire,
    input  logic [COL_W-1:0] i_player_x,
    input  logic             i_hit,
    output logic [COL_W-1:0] o_bullet_x,
    output logic [ROW_W-1:0] o_bullet_y,
    output logic             o_bullet_active,
    output logic             o_miss
);

    localparam logic [ROW_W-1:0] START_Y = ROW_W'(START_ROW);
    localparam logic [3:0]       CD_LAST = 4'(COOLDOWN - 1);

    // Fire button synchronizer and edge detect.
    logic fire_meta;
    logic fire_sync;
    logic fire_prev;
    logic sample_valid_1;
    logic sample_valid_2;
    logic fire_armed;
    logic fire_event;

    // The button only arms once a genuine post-reset low level has been seen,
    // so a button held through reset release cannot launch a bullet.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            fire_meta      <= 1'b0;
            fire_sync      <= 1'b0;
            fire_prev      <= 1'b0;
            sample_valid_1 <= 1'b0;
            sample_valid_2 <= 1'b0;
            fire_armed     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its source; blocking would collapse the chain.
            fire_meta      <= i_fire;
            fire_sync      <= fire_meta;
            fire_prev      <= fire_sync;
            sample_valid_1 <= 1'b1;
            sample_valid_2 <= sample_valid_1;
            if (sample_valid_2 && !fire_sync) begin
                fire_armed <= 1'b1;
            end
        end
    end

    assign fire_event = fire_sync & ~fire_prev & fire_armed;

    // Step prescaler.
    logic tick;
    logic restart;

    bullet_tick #(
        .SPEED(SPEED)
    ) u_tick (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .restart    (restart),
        .tick       (tick)
    );

    // FSM state and registered outputs.
    bullet_state_t    state;
    bullet_state_t    state_nxt;
    logic [COL_W-1:0] x_nxt;
    logic [ROW_W-1:0] y_nxt;
    logic             miss_nxt;
    logic [3:0]       cd_cnt;
    logic [3:0]       cd_nxt;

    // Next-state and next-output decode; a hit wins over a coincident tick.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        x_nxt     = o_bullet_x;
        y_nxt     = o_bullet_y;
        miss_nxt  = 1'b0;
        cd_nxt    = cd_cnt;
        restart   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fire_event) begin
                    state_nxt = ST_FLYING;
                    x_nxt     = i_player_x;
                    y_nxt     = START_Y;
                    restart   = 1'b1;
                end
            end
            ST_FLYING: begin
                if (i_hit) begin
                    state_nxt = ST_COOLDOWN;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    cd_nxt    = '0;
                    restart   = 1'b1;
                end else if (tick) begin
                    if (o_bullet_y <= 4'd1) begin
                        state_nxt = ST_IDLE;
                        x_nxt     = '0;
                        y_nxt     = '0;
                        miss_nxt  = 1'b1;
                    end else begin
                        y_nxt = o_bullet_y - 4'd1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cd_cnt == CD_LAST) begin
                        state_nxt = ST_IDLE;
                        cd_nxt    = '0;
                    end else begin
                        cd_nxt = cd_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                x_nxt     = '0;
                y_nxt     = '0;
                cd_nxt    = '0;
            end
        endcase
    end

    // State, cooldown counter and output registers.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            cd_cnt          <= '0;
            o_bullet_x      <= '0;
            o_bullet_y      <= '0;
            o_bullet_active <= 1'b0;
            o_miss          <= 1'b0;
        end else begin
            state           <= state_nxt;
            cd_cnt          <= cd_nxt;
            o_bullet_x      <= x_nxt;
            o_bullet_y      <= y_nxt;
            o_bullet_active <= (state_nxt == ST_FLYING);
            o_miss          <= miss_nxt;
        end
    end

endmodule
